// File: rtl/sm3_msg_pack.sv
// sm3_msg_pack: packs a valid/ready byte stream big-endian into INPT_DW-bit words
// with an MSB-aligned byte-valid mask and a last flag for the SM3 pad stage.
module sm3_msg_pack #(
  parameter int unsigned INPT_DW     = 32,
  parameter int unsigned INPT_BYTE_W = INPT_DW / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             byte_d_i,
  input  logic                   byte_vld_i,
  input  logic                   byte_lst_i,
  output logic                   byte_rdy_o,
  output logic [INPT_DW-1:0]     msg_inpt_d_o,
  output logic [INPT_BYTE_W-1:0] msg_inpt_vld_byte_o,
  output logic                   msg_inpt_vld_o,
  output logic                   msg_inpt_lst_o,
  input  logic                   msg_inpt_rdy_i
);

  localparam int unsigned CntW = $clog2(INPT_BYTE_W);
  localparam logic [CntW-1:0] CntMax = CntW'(INPT_BYTE_W - 1);

  logic [INPT_DW-1:0]     acc_q, acc_d, merged;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [INPT_BYTE_W-1:0] mask_new, mask_q, mask_d;
  logic [INPT_DW-1:0]     out_q, out_d;
  logic                   lst_q, lst_d, vld_q, vld_d;
  logic                   byte_acc, complete;

  // Ready ignores byte_vld_i/byte_lst_i so the source sees a stable ready.
  assign byte_rdy_o = !vld_q || msg_inpt_rdy_i;
  assign byte_acc   = byte_vld_i && byte_rdy_o;
  assign complete   = byte_acc && ((cnt_q == CntMax) || byte_lst_i);

  // Merge the incoming byte at slot cnt, zero slots past it, and build the mask.
  always_comb begin
    merged   = acc_q;
    mask_new = '0;
    for (int unsigned i = 0; i < INPT_BYTE_W; i++) begin
      if (CntW'(i) <= cnt_q) begin
        mask_new[INPT_BYTE_W-1-i] = 1'b1;
      end else begin
        merged[INPT_DW-1-8*i -: 8] = 8'h00;
      end
      if (CntW'(i) == cnt_q) begin
        merged[INPT_DW-1-8*i -: 8] = byte_d_i;
      end
    end
  end

  // Accumulator and fill counter: restart on completion, advance on other bytes.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (complete) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (byte_acc) begin
      acc_d = merged;
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Output register: reload on completion (even during a transfer), else clear on transfer.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    lst_d  = lst_q;
    vld_d  = vld_q;
    if (complete) begin
      out_d  = merged;
      mask_d = mask_new;
      lst_d  = byte_lst_i;
      vld_d  = 1'b1;
    end else if (vld_q && msg_inpt_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  // State registers; reset drops any partial or held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      mask_q <= '0;
      lst_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      mask_q <= mask_d;
      lst_q  <= lst_d;
      vld_q  <= vld_d;
    end
  end

  assign msg_inpt_d_o        = out_q;
  assign msg_inpt_vld_byte_o = mask_q;
  assign msg_inpt_lst_o      = lst_q;
  assign msg_inpt_vld_o      = vld_q;

endmodule

// File: tb/tb_sm3_msg_pack.sv
// Bench for sm3_msg_pack: a 32-bit and a 64-bit instance checked against a
// message-level reference model (chunk, pad, mask) through a word scoreboard.
module tb_sm3_msg_pack;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
    logic        l;
  } word_t;

  logic            clk, rst_n;
  logic [1:0][7:0] bd;
  logic [1:0]      bvld, blst, brdy, mvld, mlst, mrdy;
  logic [1:0][63:0] md;
  logic [1:0][7:0] mm;
  logic [31:0]     d32;
  logic [3:0]      m32;
  logic [63:0]     d64;
  logic [7:0]      m64;

  word_t exp0[$], exp1[$];
  int    n_chk, n_pass;
  bit    bp_force, rand_rdy;
  bit   [1:0]       hold;
  logic [1:0][63:0] hd;
  logic [1:0][7:0]  hm;
  logic [1:0]       hl;

  assign md[0] = {32'h0, d32};
  assign mm[0] = {4'h0, m32};
  assign md[1] = d64;
  assign mm[1] = m64;

  sm3_msg_pack #(.INPT_DW(32)) u_dut32 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .byte_d_i            (bd[0]),
    .byte_vld_i          (bvld[0]),
    .byte_lst_i          (blst[0]),
    .byte_rdy_o          (brdy[0]),
    .msg_inpt_d_o        (d32),
    .msg_inpt_vld_byte_o (m32),
    .msg_inpt_vld_o      (mvld[0]),
    .msg_inpt_lst_o      (mlst[0]),
    .msg_inpt_rdy_i      (mrdy[0])
  );

  sm3_msg_pack #(.INPT_DW(64)) u_dut64 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .byte_d_i            (bd[1]),
    .byte_vld_i          (bvld[1]),
    .byte_lst_i          (blst[1]),
    .byte_rdy_o          (brdy[1]),
    .msg_inpt_d_o        (d64),
    .msg_inpt_vld_byte_o (m64),
    .msg_inpt_vld_o      (mvld[1]),
    .msg_inpt_lst_o      (mlst[1]),
    .msg_inpt_rdy_i      (mrdy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: split the message into word-sized chunks, left-justify each.
  task automatic build(input int k, input bq_t msg);
    int bw, n;
    word_t w;
    bw = (k == 0) ? 4 : 8;
    for (int s = 0; s < msg.size(); s += bw) begin
      n   = (msg.size() - s < bw) ? msg.size() - s : bw;
      w.d = '0;
      w.m = '0;
      for (int j = 0; j < n; j++) begin
        w.d[(bw-1-j)*8 +: 8] = msg[s+j];
        w.m[bw-1-j]          = 1'b1;
      end
      w.l = (s + n == msg.size());
      if (k == 0) exp0.push_back(w);
      else exp1.push_back(w);
    end
  endtask

  task automatic send_byte(input int k, input logic [7:0] d, input logic l, input bit cmp);
    int waited;
    bit accepted;
    bd[k]   = d;
    blst[k] = l;
    bvld[k] = 1'b1;
    waited  = 0;
    forever begin
      @(negedge clk);
      accepted = brdy[k];
      @(posedge clk);
      #1;
      if (accepted) break;
      waited++;
      if (waited > 300) begin
        chk("byte_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    bvld[k] = 1'b0;
    blst[k] = 1'b0;
    if (cmp) chk("vld_latency", 64'(mvld[k]), 64'd1);
  endtask

  task automatic send_msg(input int k, input bq_t msg, input bit gaps);
    int bw;
    bw = (k == 0) ? 4 : 8;
    build(k, msg);
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(k, msg[i], i == msg.size() - 1,
                (i % bw == bw - 1) || (i == msg.size() - 1));
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || mvld != 2'b00) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 500) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_reset(input int k);
    chk("rst_vld", 64'(mvld[k]), 64'd0);
    chk("rst_lst", 64'(mlst[k]), 64'd0);
    chk("rst_data", md[k], 64'd0);
    chk("rst_mask", 64'(mm[k]), 64'd0);
    chk("rst_byte_rdy", 64'(brdy[k]), 64'd1);
  endtask

  // Reset pulse starting mid-cycle; outputs are checked before any clock edge.
  task automatic pulse_reset(input int k);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(k);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic mon(input int k);
    word_t w;
    if (!rst_n) begin
      hold[k] = 1'b0;
      return;
    end
    chk("byte_rdy_rule", 64'(brdy[k]), 64'(!mvld[k] || mrdy[k]));
    if (hold[k]) begin
      chk("hold_vld", 64'(mvld[k]), 64'd1);
      chk("hold_data", md[k], hd[k]);
      chk("hold_mask", 64'(mm[k]), 64'(hm[k]));
      chk("hold_lst", 64'(mlst[k]), 64'(hl[k]));
    end
    if (mvld[k] && mrdy[k]) begin
      if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        w = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        chk("word_data", md[k], w.d);
        chk("word_mask", 64'(mm[k]), 64'(w.m));
        chk("word_lst", 64'(mlst[k]), 64'(w.l));
      end
    end
    hold[k] = mvld[k] && !mrdy[k];
    hd[k]   = md[k];
    hm[k]   = mm[k];
    hl[k]   = mlst[k];
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Padder-side ready: forced low for backpressure, optionally random.
  initial begin
    mrdy = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      mrdy[0] = bp_force ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  initial begin
    bq_t m;
    int  len;
    n_chk    = 0;
    n_pass   = 0;
    hold     = '0;
    bp_force = 1'b0;
    rand_rdy = 1'b0;
    bvld     = '0;
    blst     = '0;
    bd       = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single full word, partial last word, multi-word message.
    m = '{8'h61, 8'h62, 8'h63, 8'h64};
    send_msg(0, m, 1'b0);
    drain();
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(0, m, 1'b0);
    drain();
    m = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_msg(0, m, 1'b0);
    drain();

    // Backpressure: hold ready low for 5 cycles with the first word valid.
    bp_force = 1'b1;
    @(posedge clk);
    #1;
    fork
      send_msg(0, m, 1'b0);
      begin : bp_ctl
        int w;
        w = 0;
        while (!mvld[0] && w < 100) begin
          @(posedge clk);
          #2;
          w++;
        end
        chk("bp_vld_seen", 64'(mvld[0]), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_byte_rdy", 64'(brdy[0]), 64'd0);
        end
        bp_force = 1'b0;
      end
    join
    drain();

    // Back-to-back messages with no gap.
    m = '{8'h61, 8'h62};
    send_msg(0, m, 1'b0);
    m = '{8'h63};
    send_msg(0, m, 1'b0);
    drain();

    // Reset with a held word, then reset with a partial word, then "abc".
    bp_force = 1'b1;
    @(posedge clk);
    #1;
    send_byte(0, 8'h11, 1'b0, 1'b0);
    send_byte(0, 8'h12, 1'b0, 1'b0);
    send_byte(0, 8'h13, 1'b0, 1'b0);
    send_byte(0, 8'h14, 1'b0, 1'b1);
    pulse_reset(0);
    bp_force = 1'b0;
    send_byte(0, 8'h78, 1'b0, 1'b0);
    send_byte(0, 8'h79, 1'b0, 1'b0);
    pulse_reset(0);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(0, m, 1'b0);
    drain();

    // 64-bit instance: reset after a partial word, then 9 bytes.
    send_byte(1, 8'haa, 1'b0, 1'b0);
    send_byte(1, 8'hbb, 1'b0, 1'b0);
    pulse_reset(1);
    m = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_msg(1, m, 1'b0);
    drain();

    // Random messages with random source gaps and random padder ready.
    rand_rdy = 1'b1;
    for (int n = 0; n < 25; n++) begin
      m.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
      send_msg(n % 2, m, 1'b1);
    end
    rand_rdy = 1'b0;
    drain();
    chk("exp0_empty", 64'(exp0.size()), 64'd0);
    chk("exp1_empty", 64'(exp1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
